// File: rtl/port_pkt_tx.sv
// port_pkt_tx: per-port packet transmitter for one ingress port of the
// 4-port switch. Client requests are queued in a small circular buffer and
// presented on valid_in/source_in/target_in/data_in. A full switch FIFO holds
// the head packet; the packet is dropped only after HOLD_TIMEOUT full edges.
// Build option: define PKT_TX_STATS_EN to implement the saturating
// sent/drop/stall statistics counters; otherwise those ports read as zero.
module port_pkt_tx #(
    parameter int PORT_ID      = 0,
    parameter int QDEPTH       = 4,
    parameter int GAP          = 1,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_target,
    input  logic [7:0]  req_data,
    output logic        req_err,
    input  logic        port_full,
    output logic        valid_in,
    output logic [3:0]  source_in,
    output logic [3:0]  target_in,
    output logic [7:0]  data_in,
    output logic        drop,
    output logic [15:0] sent_cnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] stall_cnt
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_TIMEOUT);
    localparam logic [CW-1:0] DEPTH_FULL = CW'(QDEPTH);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TIMEOUT - 1);
    localparam logic [3:0]    GAP_LAST   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [3:0]    SRC_MASK   = 4'(1 << PORT_ID);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    gap_q, gap_d;
    logic          req_ready_q, req_ready_d;
    logic          req_err_q, req_err_d;
    logic          drop_q, drop_d;

    logic          req_fire;
    logic          req_bad;
    logic          push;
    logic          pop;
    logic          accept;
    logic          stall;
    logic [11:0]   head;

    // Entry = {target, payload}; the head is addressed by the read pointer.
    logic [11:0]   mem_q [QDEPTH];

    assign req_fire = req_valid && req_ready_q;
    assign req_bad  = (req_target == 4'b0000) || req_target[PORT_ID];
    assign push     = req_fire && !req_bad;
    assign count_q  = wr_ptr_q - rd_ptr_q;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    // Queue storage: written on every legal handshake.
    // NOTE: the payload array has no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {req_target, req_data};
        end
    end

    // Decide pop/drop for the head, advance pointers, then choose the next state.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        pop         = 1'b0;
        accept      = 1'b0;
        stall       = 1'b0;
        drop_d      = 1'b0;
        req_err_d   = req_fire && req_bad;

        if (state_q == S_SEND) begin
            if (!port_full) begin
                accept = 1'b1;
                pop    = 1'b1;
            end else begin
                stall = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    pop    = 1'b1;
                    drop_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
        end
        if (pop) begin
            hold_d = '0;
        end

        wr_ptr_d    = wr_ptr_q + CW'(push);
        rd_ptr_d    = rd_ptr_q + CW'(pop);
        count_d     = wr_ptr_d - rd_ptr_d;
        req_ready_d = (count_d != DEPTH_FULL);

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (pop) begin
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = (count_d != '0) ? S_SEND : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = (count_d != '0) ? S_SEND : S_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointers, timers and the one-cycle pulse registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_q      <= '0;
            gap_q       <= '0;
            req_ready_q <= 1'b1;
            req_err_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            req_ready_q <= req_ready_d;
            req_err_q   <= req_err_d;
            drop_q      <= drop_d;
        end
    end

    assign valid_in  = (state_q == S_SEND);
    assign source_in = SRC_MASK;
    assign target_in = valid_in ? head[11:8] : 4'b0000;
    assign data_in   = valid_in ? head[7:0] : 8'h00;
    assign req_ready = req_ready_q;
    assign req_err   = req_err_q;
    assign drop      = drop_q;

`ifdef PKT_TX_STATS_EN
    logic [15:0] sent_cnt_q, sent_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating statistics: they stop at 0xFFFF instead of wrapping.
    always_comb begin
        sent_cnt_d  = sent_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && (sent_cnt_q != 16'hFFFF)) begin
            sent_cnt_d = sent_cnt_q + 16'd1;
        end
        if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            sent_cnt_q  <= sent_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sent_cnt  = sent_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = accept | stall;
    assign sent_cnt     = 16'h0000;
    assign drop_cnt     = 16'h0000;
    assign stall_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_port_pkt_tx.sv
// Testbench for port_pkt_tx: three instances with different parameters share
// one stimulus stream; a queue-level reference model per instance predicts
// every output each cycle, and directed scenarios pin the model with
// hand-computed values before a long randomized run.
`timescale 1ns/1ps
module tb_port_pkt_tx;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_target;
    logic [7:0]  req_data;
    logic        port_full;

    logic        o_ready [N];
    logic        o_err   [N];
    logic        o_valid [N];
    logic        o_drop  [N];
    logic [3:0]  o_src   [N];
    logic [3:0]  o_tgt   [N];
    logic [7:0]  o_data  [N];
    logic [15:0] o_sent  [N];
    logic [15:0] o_dropc [N];
    logic [15:0] o_stall [N];

    // Instance parameters, mirrored for the model.
    int m_port  [N] = '{1, 1, 2};
    int m_depth [N] = '{4, 4, 8};
    int m_gap   [N] = '{1, 2, 0};
    int m_ht    [N] = '{16, 8, 5};

    always #5 clk = ~clk;

    port_pkt_tx #(.PORT_ID(1), .QDEPTH(4), .GAP(1), .HOLD_TIMEOUT(16)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_ready[0]),
        .req_target(req_target), .req_data(req_data), .req_err(o_err[0]),
        .port_full(port_full), .valid_in(o_valid[0]), .source_in(o_src[0]),
        .target_in(o_tgt[0]), .data_in(o_data[0]), .drop(o_drop[0]),
        .sent_cnt(o_sent[0]), .drop_cnt(o_dropc[0]), .stall_cnt(o_stall[0])
    );

    port_pkt_tx #(.PORT_ID(1), .QDEPTH(4), .GAP(2), .HOLD_TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_ready[1]),
        .req_target(req_target), .req_data(req_data), .req_err(o_err[1]),
        .port_full(port_full), .valid_in(o_valid[1]), .source_in(o_src[1]),
        .target_in(o_tgt[1]), .data_in(o_data[1]), .drop(o_drop[1]),
        .sent_cnt(o_sent[1]), .drop_cnt(o_dropc[1]), .stall_cnt(o_stall[1])
    );

    port_pkt_tx #(.PORT_ID(2), .QDEPTH(8), .GAP(0), .HOLD_TIMEOUT(5)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_ready[2]),
        .req_target(req_target), .req_data(req_data), .req_err(o_err[2]),
        .port_full(port_full), .valid_in(o_valid[2]), .source_in(o_src[2]),
        .target_in(o_tgt[2]), .data_in(o_data[2]), .drop(o_drop[2]),
        .sent_cnt(o_sent[2]), .drop_cnt(o_dropc[2]), .stall_cnt(o_stall[2])
    );

    // Reference model state: a FIFO as an array with monotonic indices,
    // whether a packet is being presented, idle cycles left and full edges seen.
    logic [11:0] mbuf [N][64];
    int          mrd [N];
    int          mwr [N];
    bit          mpres [N];
    bit          mready [N];
    bit          merr [N];
    bit          mdrop [N];
    int          mgap [N];
    int          mhold [N];
    int          msent [N];
    int          mdropc [N];
    int          mstall [N];
    logic [7:0]  deliv [$];

    int n_checks = 0;
    int n_err    = 0;
    bit armed    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // Advance every model by one rising edge using the pre-edge inputs.
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            int  sz0;
            bit  bad;
            if (rst) begin
                mrd[k] = 0; mwr[k] = 0; mpres[k] = 1'b0; mready[k] = 1'b1;
                merr[k] = 1'b0; mdrop[k] = 1'b0; mgap[k] = 0; mhold[k] = 0;
                msent[k] = 0; mdropc[k] = 0; mstall[k] = 0;
            end else begin
                sz0 = mwr[k] - mrd[k];
                bad = (req_target == 4'b0000) || req_target[m_port[k]];
                merr[k]  = req_valid && mready[k] && bad;
                mdrop[k] = 1'b0;
                if (req_valid && mready[k] && !bad) begin
                    mbuf[k][mwr[k][5:0]] = {req_target, req_data};
                    mwr[k]++;
                end
                if (mpres[k]) begin
                    if (port_full) mstall[k] = sat_inc(mstall[k]);
                    if (!port_full || (mhold[k] == m_ht[k] - 1)) begin
                        if (!port_full) begin
                            msent[k] = sat_inc(msent[k]);
                            if (k == 0) deliv.push_back(mbuf[0][mrd[0][5:0]][7:0]);
                        end else begin
                            mdrop[k]  = 1'b1;
                            mdropc[k] = sat_inc(mdropc[k]);
                        end
                        mrd[k]++;
                        mhold[k] = 0;
                        if (m_gap[k] > 0) begin
                            mpres[k] = 1'b0;
                            mgap[k]  = m_gap[k];
                        end else begin
                            mpres[k] = (mwr[k] - mrd[k]) > 0;
                        end
                    end else begin
                        mhold[k]++;
                    end
                end else if (mgap[k] > 0) begin
                    mgap[k]--;
                    if (mgap[k] == 0) mpres[k] = (mwr[k] - mrd[k]) > 0;
                end else begin
                    mpres[k] = sz0 > 0;
                end
                mready[k] = (mwr[k] - mrd[k]) != m_depth[k];
            end
        end
    endtask

    // Compare every output of every instance against its model.
    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            logic [11:0] hd;
            hd = mpres[k] ? mbuf[k][mrd[k][5:0]] : 12'h000;
            check($sformatf("valid_in[%0d]", k),  32'(o_valid[k]), 32'(mpres[k]));
            check($sformatf("target_in[%0d]", k), 32'(o_tgt[k]),   32'(hd[11:8]));
            check($sformatf("data_in[%0d]", k),   32'(o_data[k]),  32'(hd[7:0]));
            check($sformatf("source_in[%0d]", k), 32'(o_src[k]),   32'(1 << m_port[k]));
            check($sformatf("req_ready[%0d]", k), 32'(o_ready[k]), 32'(mready[k]));
            check($sformatf("req_err[%0d]", k),   32'(o_err[k]),   32'(merr[k]));
            check($sformatf("drop[%0d]", k),      32'(o_drop[k]),  32'(mdrop[k]));
`ifdef PKT_TX_STATS_EN
            check($sformatf("sent_cnt[%0d]", k),  32'(o_sent[k]),  32'(msent[k]));
            check($sformatf("drop_cnt[%0d]", k),  32'(o_dropc[k]), 32'(mdropc[k]));
            check($sformatf("stall_cnt[%0d]", k), 32'(o_stall[k]), 32'(mstall[k]));
`else
            check($sformatf("sent_cnt[%0d]", k),  32'(o_sent[k]),  32'd0);
            check($sformatf("drop_cnt[%0d]", k),  32'(o_dropc[k]), 32'd0);
            check($sformatf("stall_cnt[%0d]", k), 32'(o_stall[k]), 32'd0);
`endif
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (armed) compare_all();
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; port_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
    endtask

    initial begin
        int sent_i;
        int guard;
        bit done;

        rst = 1'b1; req_valid = 1'b0; req_target = 4'b0000;
        req_data = 8'h00; port_full = 1'b0;

        // Reset state and a single packet on instance a (PORT_ID=1).
        do_reset();
        check("rst_valid", 32'(o_valid[0]), 32'd0);
        check("rst_ready", 32'(o_ready[0]), 32'd1);
        check("rst_source", 32'(o_src[0]), 32'h2);
        check("rst_target", 32'(o_tgt[0]), 32'h0);
`ifdef PKT_TX_STATS_EN
        check("rst_sent", 32'(o_sent[0]), 32'd0);
`endif
        req_valid = 1'b1; req_target = 4'b0100; req_data = 8'hA5;
        tick();
        req_valid = 1'b0;
        check("s1_idle_after_push", 32'(o_valid[0]), 32'd0);
        tick();
        check("s1_valid", 32'(o_valid[0]), 32'd1);
        check("s1_source", 32'(o_src[0]), 32'h2);
        check("s1_target", 32'(o_tgt[0]), 32'h4);
        check("s1_data", 32'(o_data[0]), 32'hA5);
        tick();
        check("s1_one_cycle", 32'(o_valid[0]), 32'd0);
        check("s1_model_sent", 32'(msent[0]), 32'd1);
`ifdef PKT_TX_STATS_EN
        check("s1_sent_cnt", 32'(o_sent[0]), 32'd1);
`endif

        // Illegal requests: own port bit, then empty mask.
        do_reset();
        req_valid = 1'b1; req_target = 4'b0010; req_data = 8'h11;
        tick();
        req_target = 4'b0000;
        check("s2_err1", 32'(o_err[0]), 32'd1);
        tick();
        req_valid = 1'b0;
        check("s2_err2", 32'(o_err[0]), 32'd1);
        tick();
        check("s2_err_end", 32'(o_err[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s2_no_valid", 32'(o_valid[0]), 32'd0);
            check("s2_ready", 32'(o_ready[0]), 32'd1);
        end

        // Backpressure: 10 full edges while presenting on instance a.
        do_reset();
        port_full = 1'b1; req_valid = 1'b1; req_target = 4'b1000; req_data = 8'h3C;
        tick();
        req_valid = 1'b0;
        tick();
        check("s3_valid", 32'(o_valid[0]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s3_hold_valid", 32'(o_valid[0]), 32'd1);
            check("s3_hold_data", 32'(o_data[0]), 32'h3C);
            check("s3_hold_target", 32'(o_tgt[0]), 32'h8);
            if (i == 9) port_full = 1'b0;
        end
        tick();
        check("s3_accepted", 32'(o_valid[0]), 32'd0);
        check("s3_model_stall", 32'(mstall[0]), 32'd10);
`ifdef PKT_TX_STATS_EN
        check("s3_stall_cnt", 32'(o_stall[0]), 32'd10);
        check("s3_drop_cnt", 32'(o_dropc[0]), 32'd0);
        check("s3_sent_cnt", 32'(o_sent[0]), 32'd1);
`endif

        // Timeout on instance b (HOLD_TIMEOUT=8, GAP=2).
        do_reset();
        port_full = 1'b1; req_valid = 1'b1; req_target = 4'b0100; req_data = 8'h11;
        tick();
        req_target = 4'b1000; req_data = 8'h22;
        tick();
        req_valid = 1'b0;
        check("s4_first", 32'(o_data[1]), 32'h11);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("s4_hold_valid", 32'(o_valid[1]), 32'd1);
            check("s4_no_drop", 32'(o_drop[1]), 32'd0);
        end
        tick();
        check("s4_drop", 32'(o_drop[1]), 32'd1);
        check("s4_gap1", 32'(o_valid[1]), 32'd0);
        check("s4_model_dropc", 32'(mdropc[1]), 32'd1);
`ifdef PKT_TX_STATS_EN
        check("s4_drop_cnt", 32'(o_dropc[1]), 32'd1);
`endif
        tick();
        check("s4_drop_once", 32'(o_drop[1]), 32'd0);
        check("s4_gap2", 32'(o_valid[1]), 32'd0);
        tick();
        check("s4_next_valid", 32'(o_valid[1]), 32'd1);
        check("s4_next_data", 32'(o_data[1]), 32'h22);
        port_full = 1'b0;
        tick();
        check("s4_next_sent", 32'(o_valid[1]), 32'd0);

        // Full queue, then a continuous drain across pointer wrap (instance a).
        do_reset();
        deliv.delete();
        port_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_target = 4'b1000; req_data = 8'(i);
            tick();
            check("s5_ready", 32'(o_ready[0]), (i >= 3) ? 32'd0 : 32'd1);
        end
        req_valid = 1'b0; port_full = 1'b0;
        sent_i = 0; guard = 0;
        while (sent_i < 20 && guard < 400) begin
            if (mready[0]) begin
                req_valid = 1'b1; req_target = 4'b0001; req_data = 8'(8'h40 + sent_i);
                sent_i++;
            end else begin
                req_valid = 1'b0;
            end
            tick();
            guard++;
        end
        req_valid = 1'b0;
        guard = 0;
        while (((mwr[0] - mrd[0]) != 0 || mpres[0] || mgap[0] != 0) && guard < 100) begin
            tick();
            guard++;
        end
        done = (mwr[0] == mrd[0]) && !mpres[0];
        check("s5_drained", 32'(done), 32'd1);
        check("s5_count", 32'(deliv.size()), 32'd24);
        for (int i = 0; i < deliv.size() && i < 24; i++) begin
            check($sformatf("s5_order[%0d]", i), 32'(deliv[i]),
                  (i < 4) ? 32'(i) : 32'(8'h40 + i - 4));
        end

        // Reset while presenting with 3 entries queued (instance a).
        do_reset();
        port_full = 1'b1; req_valid = 1'b1; req_target = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            req_data = 8'(8'h70 + i);
            tick();
        end
        req_valid = 1'b0;
        check("s6_sending", 32'(o_valid[0]), 32'd1);
        check("s6_queued", 32'(mwr[0] - mrd[0]), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_valid", 32'(o_valid[0]), 32'd0);
        check("s6_ready", 32'(o_ready[0]), 32'd1);
        check("s6_drop", 32'(o_drop[0]), 32'd0);
`ifdef PKT_TX_STATS_EN
        check("s6_stall", 32'(o_stall[0]), 32'd0);
        check("s6_sent", 32'(o_sent[0]), 32'd0);
`endif
        port_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s6_discarded", 32'(o_valid[0]), 32'd0);
            check("s6_no_drop", 32'(o_drop[0]), 32'd0);
        end

        // Randomized traffic with bursty backpressure and rare resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            req_valid  = ($urandom_range(0, 99) < 55);
            req_target = 4'($urandom_range(0, 15));
            req_data   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 8) port_full = ~port_full;
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; req_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/port_pkt_tx.md
# port_pkt_tx

Synthesizable per-port packet transmitter that drives one ingress port of the 4-port switch, the hardware counterpart of the bench's packet driver. It accepts packet requests from a local client, queues them, and presents them on the port's `valid_in`/`source_in`/`target_in`/`data_in` pins. It honours the ingress FIFO-full indication by holding rather than dropping, and drops a packet only after a bounded hold timeout.

## Interface
Parameters:
- PORT_ID, 0: this port's index 0..3; fixes `source_in` = 1 << PORT_ID.
- QDEPTH, 4: request queue entries; power of two, 2..16.
- GAP, 1: minimum idle cycles after each accepted or dropped packet; 0..15.
- HOLD_TIMEOUT, 64: consecutive full cycles before the head packet is dropped; ≥2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  queue can take a request.
- req_target  in  4  one-hot or multi-hot destination mask.
- req_data  in  8  payload byte.
- req_err  out  1  one-cycle pulse: illegal request consumed and discarded.
- port_full  in  1  switch ingress FIFO full.
- valid_in  out  1  packet presented to switch.
- source_in  out  4  constant 1 << PORT_ID.
- target_in  out  4  head packet target.
- data_in  out  8  head packet payload.
- drop  out  1  one-cycle pulse: head packet discarded on timeout.
- sent_cnt  out  16  packets accepted by switch (stats).
- drop_cnt  out  16  timeout drops (stats).
- stall_cnt  out  16  cycles with valid_in && port_full (stats).

## Operation
- Request handshake: a transfer occurs at the rising edge with req_valid && req_ready. req_ready = !queue_full, registered from occupancy. There is no bypass: push while full is impossible.
- Illegal request: req_target == 0, or req_target[PORT_ID] == 1. It is consumed by the handshake, not queued, and req_err pulses the next cycle.
- Switch handshake: the switch accepts the packet at an edge where valid_in && !port_full. valid_in and the payload stay stable until acceptance or drop.
- FSM states:
  - IDLE: valid_in = 0. Moves to SEND when the queue is non-empty.
  - SEND: valid_in = 1, showing the head packet.
    - Accepted: pop, sent_cnt++. Go to GAP if GAP > 0. Otherwise stay in SEND if more entries are queued, else go to IDLE.
    - Full: hold_timer++, stall_cnt++.
    - Drop: when hold_timer reaches HOLD_TIMEOUT-1 and port_full is still high, pop, pulse drop, drop_cnt++, then go to GAP or IDLE using the same rule as acceptance.
    - hold_timer clears on every pop.
  - GAP: valid_in = 0 for exactly GAP cycles, then SEND if the queue is non-empty, else IDLE.
- Queue: circular buffer with read/write pointers of width log2(QDEPTH) plus a wrap bit. Pointers wrap at QDEPTH. A simultaneous push and pop keeps occupancy unchanged.
- Counters: 16-bit, saturate at 0xFFFF, never wrap.

## Timing
- Reset (rst high at an edge) clears all of the following at that edge:
  - State goes to IDLE; pointers and hold_timer clear.
  - valid_in = 0, target_in = 0, data_in = 0.
  - req_err = 0, drop = 0, all counters = 0.
  - req_ready = 1 from the cycle after reset deasserts.
  - source_in is constant and unaffected.
- Reset mid-packet discards all queued packets with no drop pulse.
- Latency: a request pushed into an empty queue in IDLE at edge N asserts valid_in after edge N+1.
- Back-to-back packets with GAP = 0 give one packet per cycle while port_full stays low.
- port_full is sampled only at edges; a combinational change within a cycle has no effect.
- Drop timing: with port_full held high from the first valid_in cycle, drop pulses in the cycle after the HOLD_TIMEOUT-th full edge.

## Configuration
- PKT_TX_STATS_EN defined: sent_cnt, drop_cnt and stall_cnt are implemented as specified.
- PKT_TX_STATS_EN undefined: the counter registers are removed and the three ports are tied to 0. The drop and req_err pulses remain.

## Test plan
- Single packet: PORT_ID=1, push target=4'b0100, data=0xA5, port_full=0 → valid_in high for exactly 1 cycle, starting 2 edges after the push, with source_in=4'b0010, target_in=4'b0100, data_in=0xA5; sent_cnt=1.
- Illegal requests: PORT_ID=1, push target=4'b0010, then target=4'b0000 → two req_err pulses, valid_in never asserts, queue stays empty.
- Backpressure: port_full high for 10 cycles during SEND → valid_in and payload stable throughout; accepted on the first low edge; stall_cnt=10, drop_cnt=0.
- Timeout: HOLD_TIMEOUT=8, port_full held high → drop pulses once after 8 full edges; drop_cnt=1; the next queued packet is presented after GAP idle cycles.
- Full queue and wrap: QDEPTH=4, port_full high, push 6 requests → req_ready low after 4. Release port_full → 20 further pushes with a continuous drain deliver all packets in order with no loss across pointer wrap.
- Reset mid-operation: rst asserted while in SEND with 3 entries queued → next cycle valid_in=0, counters=0, req_ready=1, no drop pulse.
